// File: rtl/demux_reg.sv
// Registered 1-to-4 demultiplexer: writes Din into one of four holding registers
// chosen by Select or by a round-robin pointer, with per-channel valid/ack and an overwrite pulse.
module demux_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Din,
    input  logic [1:0]       Select,
    input  logic             We,
    input  logic             Auto,
    input  logic             Clr,
    input  logic [3:0]       Ack,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       Valid,
    output logic [1:0]       Ptr,
    output logic             Ovf
);

    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       valid_q, valid_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       tgt;

    assign tgt = Auto ? ptr_q : Select;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        ovf_d   = 1'b0;
        if (Clr) begin
            for (int i = 0; i < 4; i++) begin
                data_d[i] = '0;
            end
            valid_d = '0;
            ptr_d   = '0;
        end else begin
            valid_d = valid_q & ~Ack;
            if (We) begin
                // An ack on the target in the same cycle means the old word was consumed.
                data_d[tgt]  = Din;
                valid_d[tgt] = 1'b1;
                ovf_d        = valid_q[tgt] & ~Ack[tgt];
                if (Auto) begin
                    ptr_d = ptr_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign A     = data_q[0];
    assign B     = data_q[1];
    assign C     = data_q[2];
    assign D     = data_q[3];
    assign Valid = valid_q;
    assign Ptr   = ptr_q;
    assign Ovf   = ovf_q;

endmodule

// File: doc/demux_reg.md
# demux_reg

Registered 1-to-4 demultiplexer: a 16-bit input word is written into one of four output holding registers (A–D), chosen either by an explicit 2-bit select or by an internal round-robin pointer. It is the write-side counterpart of the 4:1 word selector, which picks one of four 16-bit words onto a single bus. Each channel carries a valid flag with a per-channel acknowledge, so downstream logic can tell fresh data from consumed data. An overwrite pulse flags lost words.

## Interface
Parameters:
- WIDTH, 16, data width of Din and of each output register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Din  in  WIDTH  write data.
- Select  in  2  explicit target channel (00=A, 01=B, 10=C, 11=D); used only when Auto=0.
- We  in  1  write strobe; one word is written per cycle in which it is high.
- Auto  in  1  1 = target is the internal pointer Ptr; 0 = target is Select.
- Clr  in  1  synchronous clear of all state.
- Ack  in  4  per-channel consume acknowledge (bit0=A … bit3=D).
- A, B, C, D  out  WIDTH  channel holding registers.
- Valid  out  4  per-channel "unconsumed data present" flags.
- Ptr  out  2  current round-robin pointer.
- Ovf  out  1  one-cycle pulse: a write overwrote unconsumed data.

## Operation
- Reset (rst_n=0, async): A=B=C=D=0, Valid=4'b0000, Ptr=2'b00, Ovf=0.
- Target channel t = Auto ? Ptr : Select, evaluated combinationally in the write cycle.
- Priority per edge: Clr > write > Ack.
- Clr=1:
  - all data registers set to 0, Valid=0, Ptr=0, Ovf=0.
  - We and Ack are ignored that cycle.
- We=1 (Clr=0):
  - register[t] <= Din; Valid[t] <= 1.
  - Other channels keep their data.
  - If Auto=1, Ptr <= Ptr+1, wrapping 3 -> 0. If Auto=0, Ptr holds.
- Overwrite: Ovf <= 1 for one cycle when We=1, Valid[t]=1 and Ack[t]=0 in the same cycle. Otherwise Ovf <= 0.
- Ack[i]=1 with no write to i: Valid[i] <= 0. Data is not cleared.
- Ack[t] coincident with a write to t: Valid[t] stays 1 and Ovf=0, because the old word was consumed.
- Multiple Ack bits may be high at once; each applies independently.
- Ack on a channel whose Valid is already 0 has no effect.
- Toggling Auto mid-stream does not change Ptr; the pointer resumes from its held value.
- Select is ignored while Auto=1.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Write latency is 1 cycle: data and Valid are visible right after the edge that samples We.
- Ptr updates on the same edge as the write.
- Ovf is high for exactly the one cycle following the offending write edge. Back-to-back overwrites produce a continuous high, one cycle per overwrite.
- Ack takes effect on the sampling edge; Valid is low in the following cycle.
- Reset mid-operation clears immediately and asynchronously. The first edge after rst_n deasserts behaves like a normal cycle.
- Throughput: one write per cycle, sustained.

## Test plan
- Reset then explicit writes: Auto=0, write 0x1111/0x2222/0x3333/0x4444 with Select=0..3 -> A..D hold those values, Valid=1111, Ptr=00, Ovf=0 throughout.
- Round-robin wrap: Auto=1, five writes 0xA0..0xA4 -> A=0xA4, B=0xA1, C=0xA2, D=0xA3, Ptr sequence 1,2,3,0,1, and one Ovf pulse on the fifth write (A unacked).
- Ack vs. write collision: Valid[1]=1, assert We (Select=01, Din=0xBEEF) with Ack=0010 in the same cycle -> B=0xBEEF, Valid[1]=1, Ovf=0. Next cycle Ack=0010 alone -> Valid[1]=0, B stays 0xBEEF.
- Clr priority: Valid=1111, Ptr=2, then Clr=1 with We=1, Din=0x5555 -> all registers 0, Valid=0, Ptr=0, no write occurs, Ovf=0.
- Async reset mid-burst: Auto=1 streaming writes, drop rst_n between edges -> outputs go to 0 immediately without a clock edge. After release, the next write lands in A.
- Auto toggle: Auto=1, two writes (Ptr=2), then Auto=0, a write with Select=11, then Auto=1 and another write -> D gets the Select write, C gets the final write, and Ptr=3 at the end.
